// File: rtl/iserdes_1_to_4_word_aligner.sv
// Serial-to-parallel receiver with an LSB-first shift register and an in-line bitslip
// training FSM that hunts for TRAIN_PATTERN and declares lock or failure.
module iserdes_1_to_4_word_aligner #(
  parameter int               WIDTH         = 4,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'b1100,
  parameter int               MATCH_COUNT   = 4,
  parameter int               MAX_SLIPS     = 8
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             D,
  input  logic                             BITSLIP,
  input  logic                             ALIGN_EN,
  output logic [WIDTH-1:0]                 Q,
  output logic                             DATA_VALID,
  output logic                             ALIGNED,
  output logic                             ALIGN_FAIL,
  output logic [$clog2(MAX_SLIPS+1)-1:0]   SLIP_COUNT
);

  localparam int CW = $clog2(WIDTH);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int SW = $clog2(MAX_SLIPS + 1);

  typedef enum logic [2:0] {IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL} state_t;

  state_t          state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]   cnt;
  logic [MW-1:0]   match_cnt;
  logic            fsm_slip;
  logic            slip_now;

  assign fsm_slip = (state == SLIP);
  assign slip_now = (BITSLIP & ~ALIGN_EN) | fsm_slip;

  // A slip freezes the bit counter for one edge, which pushes the word boundary one bit later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr         <= '0;
      cnt        <= '0;
      Q          <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      sr         <= {D, sr[WIDTH-1:1]};
      DATA_VALID <= 1'b0;
      if (!slip_now) begin
        if (cnt == CW'(WIDTH-1)) begin
          cnt        <= '0;
          Q          <= {D, sr[WIDTH-1:1]};
          DATA_VALID <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      SLIP_COUNT <= '0;
      match_cnt  <= '0;
      ALIGNED    <= 1'b0;
      ALIGN_FAIL <= 1'b0;
    end else if (!ALIGN_EN) begin
      // A slip already under way still gets counted before returning to IDLE.
      state      <= IDLE;
      ALIGNED    <= 1'b0;
      ALIGN_FAIL <= 1'b0;
      if (state == SLIP && SLIP_COUNT != SW'(MAX_SLIPS))
        SLIP_COUNT <= SLIP_COUNT + 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state      <= CHECK;
          SLIP_COUNT <= '0;
          match_cnt  <= '0;
          ALIGNED    <= 1'b0;
          ALIGN_FAIL <= 1'b0;
        end
        CHECK: begin
          if (DATA_VALID) begin
            if (Q == TRAIN_PATTERN) begin
              if (match_cnt == MW'(MATCH_COUNT-1)) begin
                state   <= LOCKED;
                ALIGNED <= 1'b1;
              end
              match_cnt <= match_cnt + 1'b1;
            end else begin
              match_cnt <= '0;
              if (SLIP_COUNT == SW'(MAX_SLIPS)) begin
                state      <= FAIL;
                ALIGN_FAIL <= 1'b1;
              end else begin
                state <= SLIP;
              end
            end
          end
        end
        SLIP: begin
          if (SLIP_COUNT != SW'(MAX_SLIPS))
            SLIP_COUNT <= SLIP_COUNT + 1'b1;
          state <= WAIT;
        end
        // The first word after a slip mixes bits from both boundaries.
        WAIT: begin
          if (DATA_VALID)
            state <= CHECK;
        end
        LOCKED: ALIGNED <= 1'b1;
        FAIL:   ALIGN_FAIL <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iserdes_1_to_4_word_aligner.sv
// Directed bench: per-cycle vector table for free-run/bitslip behaviour plus
// hand-written training, failure, reset and disable sequences.
module tb_iserdes_1_to_4_word_aligner;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       D = 1'b0;
  logic       BITSLIP = 1'b0;
  logic       ALIGN_EN = 1'b0;
  logic [3:0] Q;
  logic       DATA_VALID;
  logic       ALIGNED;
  logic       ALIGN_FAIL;
  logic [3:0] SLIP_COUNT;

  iserdes_1_to_4_word_aligner #(
    .WIDTH(4), .TRAIN_PATTERN(4'b1100), .MATCH_COUNT(4), .MAX_SLIPS(8)
  ) dut (
    .CLK(CLK), .RST(RST), .D(D), .BITSLIP(BITSLIP), .ALIGN_EN(ALIGN_EN),
    .Q(Q), .DATA_VALID(DATA_VALID), .ALIGNED(ALIGNED), .ALIGN_FAIL(ALIGN_FAIL),
    .SLIP_COUNT(SLIP_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       d;
    logic       bs;
    logic       en;
    logic       exp_dv;
    logic [3:0] exp_q;
  } vec_t;

  vec_t tbl[$];
  logic strm[4];
  int   n_vec = 0;
  int   n_err = 0;
  int   k = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (edge %0d): got %0d, expected %0d", nm, k, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic rst, input logic d, input logic bs, input logic en);
    RST = rst; D = d; BITSLIP = bs; ALIGN_EN = en;
    @(posedge CLK);
    #1;
    if (rst) k = 0;
    else     k++;
  endtask

  task automatic stream_step(input logic en);
    step(1'b0, strm[k % 4], 1'b0, en);
  endtask

  // Reset, then train on repeating 0,1,1,0 until lock at edge 44.
  task automatic train_to_lock();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 44; i++) begin
      stream_step(1'b1);
      if (k == 4) begin
        chk("train_first_dv", int'(DATA_VALID), 1);
        chk("train_first_q", int'(Q), 4'b0110);
      end
      if (k == 43) chk("train_not_yet_aligned", int'(ALIGNED), 0);
    end
    chk("train_aligned", int'(ALIGNED), 1);
    chk("train_slip_count", int'(SLIP_COUNT), 3);
    chk("train_locked_q", int'(Q), 4'b1100);
    chk("train_no_fail", int'(ALIGN_FAIL), 0);
  endtask

  initial begin
    strm = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Free-run: bits 1,0,1,1,0,1,1,0 -> 1101 at edge 4, 0110 at edge 8.
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1101});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110});
    // External slip on the word-complete cycle: word moves to edge 5, boundary one bit later.
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011});
    // Same pulse with ALIGN_EN=1 is ignored.
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1101});

    // Reset state before any vector.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_q", int'(Q), 0);
    chk("rst_dv", int'(DATA_VALID), 0);
    chk("rst_aligned", int'(ALIGNED), 0);
    chk("rst_fail", int'(ALIGN_FAIL), 0);
    chk("rst_slip", int'(SLIP_COUNT), 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].d, tbl[i].bs, tbl[i].en);
      chk($sformatf("vec%0d_dv", i), int'(DATA_VALID), int'(tbl[i].exp_dv));
      chk($sformatf("vec%0d_q", i), int'(Q), int'(tbl[i].exp_q));
    end

    // Training on 0,1,1,0 then reset mid-word while locked.
    train_to_lock();
    stream_step(1'b1);
    stream_step(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("lockrst_q", int'(Q), 0);
    chk("lockrst_dv", int'(DATA_VALID), 0);
    chk("lockrst_aligned", int'(ALIGNED), 0);
    chk("lockrst_slip", int'(SLIP_COUNT), 0);
    chk("lockrst_fail", int'(ALIGN_FAIL), 0);
    for (int i = 0; i < 4; i++) begin
      stream_step(1'b1);
      chk($sformatf("lockrst_dv_e%0d", k), int'(DATA_VALID), (k == 4) ? 1 : 0);
    end
    chk("lockrst_first_q", int'(Q), 4'b0110);

    // Lock again, then drop ALIGN_EN: ALIGNED clears, cadence and SLIP_COUNT unchanged.
    train_to_lock();
    stream_step(1'b0);
    chk("drop_aligned", int'(ALIGNED), 0);
    chk("drop_slip_hold", int'(SLIP_COUNT), 3);
    for (int i = 0; i < 6; i++) begin
      stream_step(1'b0);
      chk($sformatf("drop_dv_e%0d", k), int'(DATA_VALID), (k == 47 || k == 51) ? 1 : 0);
      if (k == 47 || k == 51) chk($sformatf("drop_q_e%0d", k), int'(Q), 4'b1100);
    end

    // Constant-zero stream exhausts the slip budget.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 150; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fail_flag", int'(ALIGN_FAIL), 1);
    chk("fail_slip_count", int'(SLIP_COUNT), 8);
    chk("fail_aligned", int'(ALIGNED), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("fail_clear", int'(ALIGN_FAIL), 0);
    chk("fail_slip_hold", int'(SLIP_COUNT), 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
